// File: rtl/el2_ifu_bp_upd_sched.sv
// el2_ifu_bp_upd_sched
// Schedules BHT counter updates from EXU mispredicts and TLU br0 commits onto
// the single shared read/write port of the IFU branch-predictor array.
// Fetch reads normally win the port; a starvation counter forces a write
// (and stalls the fetch read) after STARVE_LIM consecutive blocked cycles.
//
// Ports:
//   clock, reset                 core clock, synchronous active-high reset
//   io_mp_upd_*                  mispredict update (valid, index, way, hist)
//   io_br0_upd_*                 commit update (valid, index, way, hist)
//   io_rd_req                    fetch wants the array port this cycle
//   io_bpred_disable             predictor disabled: flush queue, block all
//   io_wr_en/index/way/hist      array write strobe and head-entry payload
//   io_rd_stall                  fetch read deferred for a forced write
//   io_q_count                   registered queue occupancy
//   io_overflow                  sticky: a mispredict update was lost
//   io_drop_cnt                  saturating count of dropped br0 updates
module el2_ifu_bp_upd_sched #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_mp_upd_valid,
  input  logic [6:0] io_mp_upd_index,
  input  logic       io_mp_upd_way,
  input  logic [1:0] io_mp_upd_hist,
  input  logic       io_br0_upd_valid,
  input  logic [6:0] io_br0_upd_index,
  input  logic       io_br0_upd_way,
  input  logic [1:0] io_br0_upd_hist,
  input  logic       io_rd_req,
  input  logic       io_bpred_disable,
  output logic       io_wr_en,
  output logic [6:0] io_wr_index,
  output logic       io_wr_way,
  output logic [1:0] io_wr_hist,
  output logic       io_rd_stall,
  output logic [2:0] io_q_count,
  output logic       io_overflow,
  output logic [7:0] io_drop_cnt
);

  localparam int unsigned EW = 10;               // {index[6:0], way, hist[1:0]}
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;           // room for DEPTH + 1
  localparam int unsigned TW = 4;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] starve_cnt;
  logic          overflow_q;
  logic [7:0]    drop_cnt_q;

  logic          empty, force_wr, write_ok, pop;
  logic          same_slot, mp_req, br_req, mp_push, br_push, mp_drop, br_drop;
  logic [SW-1:0] space;
  logic [CW-1:0] n_push;
  logic [EW-1:0] mp_entry, br_entry, head;

  // Port arbitration and push/drop decisions
  always_comb begin
    empty     = (count == '0);
    force_wr  = (starve_cnt == TW'(STARVE_LIM));
    write_ok  = !empty && !io_bpred_disable && (!io_rd_req || force_wr);
    pop       = write_ok;

    mp_entry  = {io_mp_upd_index, io_mp_upd_way, io_mp_upd_hist};
    br_entry  = {io_br0_upd_index, io_br0_upd_way, io_br0_upd_hist};
    head      = mem[rd_ptr];

    // Same index/way in one cycle: the mispredict value supersedes the commit
    same_slot = io_mp_upd_valid && io_br0_upd_valid &&
                (io_mp_upd_index == io_br0_upd_index) &&
                (io_mp_upd_way == io_br0_upd_way);
    mp_req    = io_mp_upd_valid && !io_bpred_disable;
    br_req    = io_br0_upd_valid && !io_bpred_disable && !same_slot;

    // Slot freed by this cycle's pop is reusable on the same edge
    space     = SW'(DEPTH) - SW'(count) + SW'(pop);
    mp_push   = mp_req && (space != '0);
    br_push   = br_req && (space > SW'(mp_push));
    mp_drop   = mp_req && !mp_push;
    br_drop   = br_req && !br_push;
    n_push    = CW'(mp_push) + CW'(br_push);
  end

  // Queue pointers, occupancy, starvation and loss accounting
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (io_bpred_disable) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(n_push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + n_push - CW'(pop);

      if (pop || empty)
        starve_cnt <= '0;
      else if (io_rd_req && !force_wr)
        starve_cnt <= starve_cnt + TW'(1);

      if (mp_drop)
        overflow_q <= 1'b1;
      if (br_drop && (drop_cnt_q != 8'hff))
        drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  // Entry storage; mp always lands first when both push together
  always_ff @(posedge clock) begin
    if (!reset && !io_bpred_disable) begin
      if (mp_push) begin
        mem[wr_ptr] <= mp_entry;
        if (br_push)
          mem[wr_ptr + PW'(1)] <= br_entry;
      end else if (br_push) begin
        mem[wr_ptr] <= br_entry;
      end
    end
  end

  // Write port driven straight from the head entry; zeroed while empty
  always_comb begin
    io_wr_en    = write_ok;
    io_wr_index = empty ? 7'd0 : head[9:3];
    io_wr_way   = empty ? 1'b0 : head[2];
    io_wr_hist  = empty ? 2'd0 : head[1:0];
    io_rd_stall = force_wr && !empty && !io_bpred_disable;
    io_q_count  = 3'(count);
    io_overflow = overflow_q;
    io_drop_cnt = drop_cnt_q;
  end

endmodule

// File: tb/tb_el2_ifu_bp_upd_sched.sv
// Directed bench for el2_ifu_bp_upd_sched (DEPTH=4, STARVE_LIM=8).
module tb_el2_ifu_bp_upd_sched;

  logic       clock = 1'b0;
  logic       reset;
  logic       mp_v, mp_way, br_v, br_way, rd_req, dis;
  logic [6:0] mp_idx, br_idx;
  logic [1:0] mp_hist, br_hist;
  logic       wr_en, wr_way, rd_stall, overflow;
  logic [6:0] wr_index;
  logic [1:0] wr_hist;
  logic [2:0] q_count;
  logic [7:0] drop_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  el2_ifu_bp_upd_sched #(.DEPTH(4), .STARVE_LIM(8)) dut (
    .clock            (clock),
    .reset            (reset),
    .io_mp_upd_valid  (mp_v),
    .io_mp_upd_index  (mp_idx),
    .io_mp_upd_way    (mp_way),
    .io_mp_upd_hist   (mp_hist),
    .io_br0_upd_valid (br_v),
    .io_br0_upd_index (br_idx),
    .io_br0_upd_way   (br_way),
    .io_br0_upd_hist  (br_hist),
    .io_rd_req        (rd_req),
    .io_bpred_disable (dis),
    .io_wr_en         (wr_en),
    .io_wr_index      (wr_index),
    .io_wr_way        (wr_way),
    .io_wr_hist       (wr_hist),
    .io_rd_stall      (rd_stall),
    .io_q_count       (q_count),
    .io_overflow      (overflow),
    .io_drop_cnt      (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1-2 ns after the edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic mp(input logic [6:0] idx, input logic way, input logic [1:0] hist);
    mp_v = 1'b1; mp_idx = idx; mp_way = way; mp_hist = hist;
  endtask

  task automatic br(input logic [6:0] idx, input logic way, input logic [1:0] hist);
    br_v = 1'b1; br_idx = idx; br_way = way; br_hist = hist;
  endtask

  task automatic idle();
    mp_v = 1'b0; br_v = 1'b0;
    mp_idx = '0; mp_way = 1'b0; mp_hist = '0;
    br_idx = '0; br_way = 1'b0; br_hist = '0;
  endtask

  task automatic chk_wr(input string tag, input logic [6:0] idx, input logic way,
                        input logic [1:0] hist);
    chk({tag, "_en"},   32'(wr_en),    32'd1);
    chk({tag, "_idx"},  32'(wr_index), 32'(idx));
    chk({tag, "_way"},  32'(wr_way),   32'(way));
    chk({tag, "_hist"}, 32'(wr_hist),  32'(hist));
  endtask

  initial begin
    reset = 1'b1; rd_req = 1'b0; dis = 1'b0;
    idle();
    step(); step();
    reset = 1'b0;
    settle();
    chk("rst_wr_en",    32'(wr_en),    32'd0);
    chk("rst_wr_index", 32'(wr_index), 32'd0);
    chk("rst_wr_way",   32'(wr_way),   32'd0);
    chk("rst_wr_hist",  32'(wr_hist),  32'd0);
    chk("rst_stall",    32'(rd_stall), 32'd0);
    chk("rst_q",        32'(q_count),  32'd0);
    chk("rst_ovf",      32'(overflow), 32'd0);
    chk("rst_drop",     32'(drop_cnt), 32'd0);

    // 1: single mp push, no bypass, written next cycle
    mp(7'h15, 1'b1, 2'b11);
    settle();
    chk("t1_nobypass", 32'(wr_en), 32'd0);
    step(); idle(); settle();
    chk("t1_q1", 32'(q_count), 32'd1);
    chk_wr("t1", 7'h15, 1'b1, 2'd3);
    step(); settle();
    chk("t1_q0",  32'(q_count), 32'd0);
    chk("t1_idle", 32'(wr_en),  32'd0);

    // 2: mp and br0 together, mp written first
    mp(7'h10, 1'b0, 2'd1); br(7'h20, 1'b1, 2'd2);
    step(); idle(); settle();
    chk("t2_q2", 32'(q_count), 32'd2);
    chk_wr("t2_a", 7'h10, 1'b0, 2'd1);
    step(); settle();
    chk("t2_q1", 32'(q_count), 32'd1);
    chk_wr("t2_b", 7'h20, 1'b1, 2'd2);
    step(); settle();
    chk("t2_q0", 32'(q_count), 32'd0);
    chk("t2_idle", 32'(wr_en), 32'd0);

    // 3: starvation forces a write after 8 blocked cycles
    rd_req = 1'b1;
    mp(7'h05, 1'b0, 2'd1);
    step(); idle();
    for (int i = 0; i < 8; i++) begin
      settle();
      chk($sformatf("t3_blk%0d", i),   32'(wr_en),    32'd0);
      chk($sformatf("t3_nost%0d", i),  32'(rd_stall), 32'd0);
      step();
    end
    settle();
    chk_wr("t3_force", 7'h05, 1'b0, 2'd1);
    chk("t3_stall", 32'(rd_stall), 32'd1);
    step(); settle();
    chk("t3_stall_off", 32'(rd_stall), 32'd0);
    chk("t3_q0",        32'(q_count),  32'd0);

    // 4: fill to 4 with reads blocking, then mp+br0 both dropped
    mp(7'h01, 1'b0, 2'd0); br(7'h02, 1'b0, 2'd1);
    step();
    mp(7'h03, 1'b1, 2'd2); br(7'h04, 1'b1, 2'd3);
    step(); idle(); settle();
    chk("t4_full", 32'(q_count), 32'd4);
    mp(7'h06, 1'b0, 2'd1); br(7'h07, 1'b0, 2'd2);
    step(); idle(); settle();
    chk("t4_q_stays", 32'(q_count),  32'd4);
    chk("t4_ovf",     32'(overflow), 32'd1);
    chk("t4_drop",    32'(drop_cnt), 32'd1);
    chk("t4_blocked", 32'(wr_en),    32'd0);
    rd_req = 1'b0;
    settle();
    chk_wr("t4_w0", 7'h01, 1'b0, 2'd0);
    step(); settle();
    chk_wr("t4_w1", 7'h02, 1'b0, 2'd1);
    step(); settle();
    chk_wr("t4_w2", 7'h03, 1'b1, 2'd2);
    step(); settle();
    chk_wr("t4_w3", 7'h04, 1'b1, 2'd3);
    step(); settle();
    chk("t4_q0",     32'(q_count),  32'd0);
    chk("t4_sticky", 32'(overflow), 32'd1);

    // 5: same index/way merge keeps mp value, no drop accounting
    mp(7'h33, 1'b1, 2'd0); br(7'h33, 1'b1, 2'd3);
    step(); idle(); settle();
    chk("t5_q1", 32'(q_count), 32'd1);
    chk_wr("t5", 7'h33, 1'b1, 2'd0);
    chk("t5_drop", 32'(drop_cnt), 32'd1);
    step(); settle();
    chk("t5_q0", 32'(q_count), 32'd0);

    // 6: disable flushes 3 queued entries and ignores the concurrent push
    rd_req = 1'b1;
    mp(7'h08, 1'b0, 2'd1); br(7'h09, 1'b0, 2'd2);
    step(); idle();
    mp(7'h0A, 1'b1, 2'd3);
    step(); idle(); settle();
    chk("t6_q3", 32'(q_count), 32'd3);
    dis = 1'b1;
    mp(7'h0B, 1'b0, 2'd1);
    settle();
    chk("t6_dis_nowr", 32'(wr_en), 32'd0);
    step(); idle(); dis = 1'b0; settle();
    chk("t6_flushed", 32'(q_count),  32'd0);
    chk("t6_no_wr",   32'(wr_en),    32'd0);
    chk("t6_ovf",     32'(overflow), 32'd1);
    chk("t6_drop",    32'(drop_cnt), 32'd1);
    rd_req = 1'b0;
    mp(7'h2A, 1'b0, 2'd2);
    step(); idle(); settle();
    chk("t6_q1", 32'(q_count), 32'd1);
    chk_wr("t6_after", 7'h2A, 1'b0, 2'd2);
    step(); settle();
    chk("t6_q0", 32'(q_count), 32'd0);

    // Reset mid-queue wins over a simultaneous push
    rd_req = 1'b1;
    mp(7'h11, 1'b0, 2'd1);
    step(); idle(); settle();
    chk("rq_q1", 32'(q_count), 32'd1);
    reset = 1'b1;
    mp(7'h12, 1'b1, 2'd2);
    step(); idle(); reset = 1'b0; settle();
    chk("rq_q0",   32'(q_count),  32'd0);
    chk("rq_wren", 32'(wr_en),    32'd0);
    chk("rq_ovf",  32'(overflow), 32'd0);
    chk("rq_drop", 32'(drop_cnt), 32'd0);
    step(); settle();
    chk("rq_idle", 32'(wr_en), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
